asic_output_classifier: RTL

Downstream consumer of the XADC sample stream produced by the XADC DRP reader. Accumulates 12-bit auxiliary-channel measurements (AUX0–AUX3, one per ASIC output neuron) over a window of complete XADC sequences and selects the channel with the largest average. Debounces the winner and publishes a 2-bit network output, a one-cycle update strobe and the winning average. The AXI configuration registers and the LED logic consume these outputs.

---
 rtl/asic_output_classifier_pkg.sv | 24 ++
 rtl/asic_output_classifier_if.sv | 26 ++
 rtl/asic_output_classifier_aux_accumulator_bank.sv | 32 +++
 rtl/asic_output_classifier.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/asic_output_classifier_pkg.sv
// Shared constants for the aux-channel output classifier.
// State encodings and aux channel indices match the XADC reader.
package asic_output_classifier_pkg;

    localparam int NUM_AUX_CH = 4;

    localparam logic [1:0] AUX0_CH = 2'd0;
    localparam logic [1:0] AUX1_CH = 2'd1;
    localparam logic [1:0] AUX2_CH = 2'd2;
    localparam logic [1:0] AUX3_CH = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_COMPARE = 2'd2;
    localparam logic [1:0] ST_DECIDE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ACCUM   = ST_ACCUM,
        COMPARE = ST_COMPARE,
        DECIDE  = ST_DECIDE
    } state_t;

endpackage

// File: rtl/asic_output_classifier_if.sv
// Sample stream in, debounced classification out.
// master = sample producer / result consumer, slave = classifier.
interface asic_output_classifier_if #(
    parameter int SAMPLE_WIDTH = 12
);
    logic                    enable;
    logic                    clear;
    logic                    sample_valid;
    logic [1:0]              sample_ch;
    logic [SAMPLE_WIDTH-1:0] sample_data;
    logic                    eos;
    logic [1:0]              network_output;
    logic                    output_valid;
    logic [SAMPLE_WIDTH-1:0] max_avg;
    logic                    overrun;

    modport master (
        output enable, clear, sample_valid, sample_ch, sample_data, eos,
        input  network_output, output_valid, max_avg, overrun
    );

    modport slave (
        input  enable, clear, sample_valid, sample_ch, sample_data, eos,
        output network_output, output_valid, max_avg, overrun
    );
endinterface

// File: rtl/asic_output_classifier_aux_accumulator_bank.sv
// Four per-channel sample accumulators with clear, add and read-mux.
// Clear has priority over add.
module aux_accumulator_bank
    import asic_output_classifier_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 12,
    parameter int ACC_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    add,
    input  logic [1:0]              add_ch,
    input  logic [SAMPLE_WIDTH-1:0] add_data,
    input  logic [1:0]              rd_idx,
    output logic [ACC_WIDTH-1:0]    rd_data
);
    logic [ACC_WIDTH-1:0] acc [NUM_AUX_CH];

    // Accumulate the addressed channel; zero the whole bank on clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_AUX_CH; i++) acc[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_AUX_CH; i++) acc[i] <= '0;
        end else if (add) begin
            acc[add_ch] <= acc[add_ch] + ACC_WIDTH'(add_data);
        end
    end

    assign rd_data = acc[rd_idx];
endmodule

// File: rtl/asic_output_classifier.sv
// Windowed argmax over AUX0-AUX3 averages with winner debounce.
// FSM: IDLE -> ACCUM -> COMPARE(4 cycles) -> DECIDE -> ACCUM.
module asic_output_classifier
    import asic_output_classifier_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 12,
    parameter int AVG_LOG2     = 4,
    parameter int STABLE_COUNT = 3
) (
    input logic                     clk,
    input logic                     rst,
    asic_output_classifier_if.slave bus
);
    localparam int ACC_WIDTH = SAMPLE_WIDTH + AVG_LOG2;
    localparam logic [3:0] STABLE_MAX = 4'(STABLE_COUNT);
    localparam logic [AVG_LOG2-1:0] LAST_SWEEP = '1;

    state_t                state;
    state_t                state_nxt;
    logic [AVG_LOG2-1:0]   sweep_cnt;
    logic [1:0]            idx;
    logic [ACC_WIDTH-1:0]  best_acc;
    logic [ACC_WIDTH-1:0]  rd_data;
    logic [1:0]            cand;
    logic [1:0]            prev_cand;
    logic [3:0]            stable_cnt;
    logic [3:0]            stable_nxt;
    logic                  publish;
    logic                  acc_clr;
    logic                  acc_add;

    aux_accumulator_bank #(
        .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .clr     (acc_clr),
        .add     (acc_add),
        .add_ch  (bus.sample_ch),
        .add_data(bus.sample_data),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, debounce arithmetic and accumulator controls.
    always_comb begin
        state_nxt  = state;
        stable_nxt = 4'd1;
        publish    = 1'b0;
        acc_clr    = 1'b0;
        acc_add    = 1'b0;

        case (state)
            IDLE:    state_nxt = ACCUM;
            ACCUM:   if (bus.eos && sweep_cnt == LAST_SWEEP) state_nxt = COMPARE;
            COMPARE: if (idx == 2'd3) state_nxt = DECIDE;
            DECIDE:  state_nxt = ACCUM;
            default: state_nxt = IDLE;
        endcase
        if (!bus.enable)    state_nxt = IDLE;
        else if (bus.clear) state_nxt = ACCUM;

        if (cand == prev_cand)
            stable_nxt = (stable_cnt >= STABLE_MAX) ? stable_cnt : stable_cnt + 4'd1;

        publish = (state == DECIDE) && bus.enable && !bus.clear &&
                  (stable_nxt >= STABLE_MAX);
        acc_clr = bus.clear || state == IDLE || state == DECIDE;
        acc_add = (state == ACCUM) && bus.sample_valid;
    end

    // Sweep counting, sequential argmax, debounce and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_cnt          <= '0;
            idx                <= '0;
            best_acc           <= '0;
            cand               <= '0;
            prev_cand          <= '0;
            stable_cnt         <= '0;
            bus.network_output <= '0;
            bus.output_valid   <= 1'b0;
            bus.max_avg        <= '0;
            bus.overrun        <= 1'b0;
        end else begin
            bus.output_valid <= publish;
            if (bus.clear) begin
                sweep_cnt          <= '0;
                idx                <= '0;
                stable_cnt         <= '0;
                prev_cand          <= '0;
                bus.network_output <= '0;
                bus.max_avg        <= '0;
                bus.overrun        <= 1'b0;
            end else if (!bus.enable) begin
                sweep_cnt  <= '0;
                idx        <= '0;
                stable_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        sweep_cnt  <= '0;
                        idx        <= '0;
                        stable_cnt <= '0;
                    end
                    ACCUM: begin
                        idx <= '0;
                        if (bus.eos) sweep_cnt <= sweep_cnt + 1'b1;
                    end
                    COMPARE: begin
                        idx <= idx + 2'd1;
                        // Strict '>' keeps the lower index on ties.
                        if (idx == 2'd0 || rd_data > best_acc) begin
                            best_acc <= rd_data;
                            cand     <= idx;
                        end
                        if (bus.sample_valid) bus.overrun <= 1'b1;
                    end
                    DECIDE: begin
                        stable_cnt <= stable_nxt;
                        prev_cand  <= cand;
                        if (publish) begin
                            bus.network_output <= cand;
                            bus.max_avg <= SAMPLE_WIDTH'(best_acc >> AVG_LOG2);
                        end
                        if (bus.sample_valid) bus.overrun <= 1'b1;
                    end
                    default: idx <= '0;
                endcase
            end
        end
    end
endmodule
